// File: rtl/button_event_scheduler.sv
// Button event scheduler: turns debounced button levels into SHORT / LONG / REPEAT /
// RELEASE_LONG events and arbitrates them round-robin onto one valid/ready port.
// Optional auto-repeat while held: define BTN_AUTOREPEAT_EN.
module button_event_scheduler #(
    parameter int unsigned NUM_BTN   = 4,
    parameter int unsigned TICK_DIV  = 12_000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_BTN-1:0]         btn_db,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(NUM_BTN)-1:0] evt_id,
    output logic [1:0]                 evt_type,
    output logic                       overflow,
    input  logic                       overflow_clr
);

    localparam int unsigned IdW   = $clog2(NUM_BTN);
    localparam int unsigned PreW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HoldW = $clog2(LONG_MS + 1);

    localparam logic [1:0] EvtShort   = 2'b00;
    localparam logic [1:0] EvtLong    = 2'b01;
    localparam logic [1:0] EvtRelLong = 2'b11;
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [1:0] EvtRepeat  = 2'b10;
    localparam logic [HoldW-1:0] RepeatCnt = HoldW'(REPEAT_MS);
`endif

    localparam logic [HoldW-1:0] LongCnt = HoldW'(LONG_MS);

    typedef enum logic [1:0] {StIdle, StPressed, StHeld} state_e;

    logic [PreW-1:0]    pre_q;
    logic               tick;
    logic [NUM_BTN-1:0] btn_prev_q;
    logic [NUM_BTN-1:0] press;

    state_e             state_q [NUM_BTN];
    state_e             state_d [NUM_BTN];
    logic [HoldW-1:0]   hold_q [NUM_BTN];
    logic [HoldW-1:0]   hold_d [NUM_BTN];
    logic [HoldW-1:0]   hold_inc [NUM_BTN];

    logic [NUM_BTN-1:0] emit;
    logic [1:0]         emit_type [NUM_BTN];

    logic [NUM_BTN-1:0] pend_valid_q, pend_valid_d;
    logic [1:0]         pend_type_q [NUM_BTN];
    logic [1:0]         pend_type_d [NUM_BTN];
    logic               drop;

    logic               load;
    logic               grant_any;
    logic [IdW-1:0]     grant_id;
    logic [IdW-1:0]     sel;
    logic [NUM_BTN-1:0] grant;
    logic [IdW-1:0]     last_grant_q, last_grant_d;

    logic               evt_valid_q, evt_valid_d;
    logic [IdW-1:0]     evt_id_q, evt_id_d;
    logic [1:0]         evt_type_q, evt_type_d;
    logic               overflow_q, overflow_d;

    assign tick  = (pre_q == PreW'(TICK_DIV - 1));
    assign press = btn_db & ~btn_prev_q;

    // Free-running 1 ms prescaler and per-button previous-level register.
    // Previous level resets to 1 so a button already held at reset release is ignored
    // until it is released and pressed again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q      <= '0;
            btn_prev_q <= '1;
        end else begin
            pre_q      <= tick ? '0 : pre_q + 1'b1;
            btn_prev_q <= btn_db;
        end
    end

    // Saturating increment of each hold counter.
    always_comb begin
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            hold_inc[i] = (hold_q[i] == '1) ? hold_q[i] : hold_q[i] + 1'b1;
        end
    end

    // Button FSM state and hold counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                state_q[i] <= StIdle;
                hold_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
            end
        end
    end

    // Button FSM next state; release is checked first so it wins over a threshold.
    always_comb begin
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
            unique case (state_q[i])
                StIdle: begin
                    if (press[i]) begin
                        state_d[i] = StPressed;
                        hold_d[i]  = '0;
                    end
                end
                StPressed: begin
                    if (!btn_db[i]) begin
                        state_d[i] = StIdle;
                    end else if (tick) begin
                        if (hold_inc[i] == LongCnt) begin
                            state_d[i] = StHeld;
                            hold_d[i]  = '0;
                        end else begin
                            hold_d[i] = hold_inc[i];
                        end
                    end
                end
                StHeld: begin
                    if (!btn_db[i]) begin
                        state_d[i] = StIdle;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (tick) begin
                        hold_d[i] = (hold_inc[i] == RepeatCnt) ? '0 : hold_inc[i];
                    end
`endif
                end
                default: state_d[i] = StIdle;
            endcase
        end
    end

    // Button FSM outputs: one-cycle emit strobe plus event type.
    always_comb begin
        emit = '0;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            emit_type[i] = EvtShort;
            unique case (state_q[i])
                StPressed: begin
                    if (!btn_db[i]) begin
                        emit[i]      = 1'b1;
                        emit_type[i] = EvtShort;
                    end else if (tick && hold_inc[i] == LongCnt) begin
                        emit[i]      = 1'b1;
                        emit_type[i] = EvtLong;
                    end
                end
                StHeld: begin
                    if (!btn_db[i]) begin
                        emit[i]      = 1'b1;
                        emit_type[i] = EvtRelLong;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (tick && hold_inc[i] == RepeatCnt) begin
                        emit[i]      = 1'b1;
                        emit_type[i] = EvtRepeat;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // Round-robin pick of the first pending entry after the last grant.
    always_comb begin
        load      = !evt_valid_q || evt_ready;
        grant     = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        sel       = '0;
        for (int k = 0; k < int'(NUM_BTN); k++) begin
            sel = IdW'((int'(last_grant_q) + 1 + k) % int'(NUM_BTN));
            if (load && !grant_any && pend_valid_q[sel]) begin
                grant_any = 1'b1;
                grant_id  = sel;
            end
        end
        grant[grant_id] = grant_any;
    end

    // Pending buffer: a granted entry may be replaced in the same cycle; otherwise a
    // second event for an occupied entry is dropped.
    always_comb begin
        drop = 1'b0;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            pend_valid_d[i] = pend_valid_q[i] & ~grant[i];
            pend_type_d[i]  = pend_type_q[i];
            if (emit[i]) begin
                if (pend_valid_q[i] && !grant[i]) begin
                    drop = 1'b1;
                end else begin
                    pend_valid_d[i] = 1'b1;
                    pend_type_d[i]  = emit_type[i];
                end
            end
        end
    end

    // Output register, last-grant pointer and sticky overflow next state.
    always_comb begin
        evt_valid_d  = evt_valid_q;
        evt_id_d     = evt_id_q;
        evt_type_d   = evt_type_q;
        last_grant_d = last_grant_q;
        if (load) begin
            evt_valid_d = grant_any;
            if (grant_any) begin
                evt_id_d     = grant_id;
                evt_type_d   = pend_type_q[grant_id];
                last_grant_d = grant_id;
            end
        end
        // A new drop outranks a same-cycle clear.
        overflow_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
    end

    // Pending buffer, arbiter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid_q <= '0;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                pend_type_q[i] <= EvtShort;
            end
            last_grant_q <= '0;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            evt_type_q   <= EvtShort;
            overflow_q   <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                pend_type_q[i] <= pend_type_d[i];
            end
            last_grant_q <= last_grant_d;
            evt_valid_q  <= evt_valid_d;
            evt_id_q     <= evt_id_d;
            evt_type_q   <= evt_type_d;
            overflow_q   <= overflow_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_type  = evt_type_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler with TICK_DIV=4, LONG_MS=10, REPEAT_MS=3.
module tb_button_event_scheduler;

    localparam int TICK_DIV = 4;
    localparam logic [1:0] T_SHORT = 2'b00;
    localparam logic [1:0] T_LONG  = 2'b01;
    localparam logic [1:0] T_REL   = 2'b11;
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [1:0] T_REP   = 2'b10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_db = '0;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [1:0] evt_id;
    logic [1:0] evt_type;
    logic       overflow;
    logic       overflow_clr = 1'b0;

    always #5 clk = ~clk;

    button_event_scheduler #(
        .NUM_BTN   (4),
        .TICK_DIV  (4),
        .LONG_MS   (10),
        .REPEAT_MS (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_db       (btn_db),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_id       (evt_id),
        .evt_type     (evt_type),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    typedef struct {
        logic [1:0] id;
        logic [1:0] typ;
        int         cyc;
    } evt_t;

    typedef struct {
        int         btn;
        int         hold;
        int         n_exp;
        logic [1:0] t0;
        logic [1:0] t1;
    } vec_t;

    evt_t evq[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   presc = 0;
    int   valid_cycles = 0;
    int   ev_base = 0;
    int   vc_base = 0;
    int   ticks = 0;

    // Cycle counter and reference model of the free-running prescaler.
    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk or posedge reset) begin
        if (reset) presc <= 0;
        else       presc <= (presc == TICK_DIV - 1) ? 0 : presc + 1;
    end

    // Record every accepted event, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && evt_valid) begin
            valid_cycles <= valid_cycles + 1;
            if (evt_ready) evq.push_back('{id: evt_id, typ: evt_type, cyc: cycle});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_evt(input string name, input int k, input logic [1:0] id,
                             input logic [1:0] typ);
        if (ev_base + k < evq.size()) begin
            check({name, " id"}, 32'(evq[ev_base + k].id), 32'(id));
            check({name, " type"}, 32'(evq[ev_base + k].typ), 32'(typ));
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: event %0d missing, got %0d events", name, k,
                     evq.size() - ev_base);
        end
    endtask

    task automatic check_gap(input string name, input int k, input int gap);
        if (ev_base + k + 1 < evq.size()) begin
            check(name, 32'(evq[ev_base + k + 1].cyc - evq[ev_base + k].cyc), 32'(gap));
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: events missing for spacing check", name);
        end
    endtask

    task automatic mark();
        ev_base = evq.size();
        vc_base = valid_cycles;
    endtask

    initial begin
        // Single-button presses: {button, cycles held, events, first type, second type}.
        vecs[0] = '{btn: 0, hold: 1,  n_exp: 1, t0: T_SHORT, t1: T_SHORT};
        vecs[1] = '{btn: 3, hold: 5,  n_exp: 1, t0: T_SHORT, t1: T_SHORT};
        vecs[2] = '{btn: 2, hold: 20, n_exp: 1, t0: T_SHORT, t1: T_SHORT};
        vecs[3] = '{btn: 1, hold: 30, n_exp: 1, t0: T_SHORT, t1: T_SHORT};
        vecs[4] = '{btn: 0, hold: 42, n_exp: 2, t0: T_LONG,  t1: T_REL};
        vecs[5] = '{btn: 3, hold: 42, n_exp: 2, t0: T_LONG,  t1: T_REL};

        steps(3);
        check("reset evt_valid", 32'(evt_valid), 0);
        check("reset evt_id", 32'(evt_id), 0);
        check("reset evt_type", 32'(evt_type), 0);
        check("reset overflow", 32'(overflow), 0);
        reset = 1'b0;
        steps(4);
        check("idle evt_valid", 32'(evt_valid), 0);

        for (int v = 0; v < 6; v++) begin
            mark();
            btn_db[vecs[v].btn] = 1'b1;
            steps(vecs[v].hold);
            btn_db[vecs[v].btn] = 1'b0;
            steps(12);
            check($sformatf("vec%0d count", v), 32'(evq.size() - ev_base), 32'(vecs[v].n_exp));
            check($sformatf("vec%0d valid cycles", v), 32'(valid_cycles - vc_base),
                  32'(vecs[v].n_exp));
            check_evt($sformatf("vec%0d ev0", v), 0, 2'(vecs[v].btn), vecs[v].t0);
            if (vecs[v].n_exp > 1) check_evt($sformatf("vec%0d ev1", v), 1, 2'(vecs[v].btn),
                                             vecs[v].t1);
        end

`ifdef BTN_AUTOREPEAT_EN
        // Hold until tick 10 plus 9 more ticks: LONG, three REPEATs, then RELEASE_LONG.
        mark();
        btn_db[0] = 1'b1;
        ticks = 0;
        for (int c = 0; c < 200 && ticks < 19; c++) begin
            step();
            if (presc == TICK_DIV - 1) ticks++;
        end
        step();
        btn_db[0] = 1'b0;
        steps(10);
        check("repeat count", 32'(evq.size() - ev_base), 5);
        check_evt("repeat long", 0, 2'd0, T_LONG);
        check_evt("repeat r1", 1, 2'd0, T_REP);
        check_evt("repeat r2", 2, 2'd0, T_REP);
        check_evt("repeat r3", 3, 2'd0, T_REP);
        check_evt("repeat release", 4, 2'd0, T_REL);
        check_gap("repeat gap0", 0, 12);
        check_gap("repeat gap1", 1, 12);
        check_gap("repeat gap2", 2, 12);
`else
        // Long hold without auto-repeat: LONG then RELEASE_LONG only.
        mark();
        btn_db[1] = 1'b1;
        steps(80);
        btn_db[1] = 1'b0;
        steps(10);
        check("long count", 32'(evq.size() - ev_base), 2);
        check_evt("long ev0", 0, 2'd1, T_LONG);
        check_evt("long ev1", 1, 2'd1, T_REL);
`endif

        // Round robin: last grant 1, then buttons 0,1,3 emit together -> 3,0,1.
        mark();
        btn_db[1] = 1'b1;
        step();
        btn_db[1] = 1'b0;
        steps(8);
        check("rr setup count", 32'(evq.size() - ev_base), 1);
        mark();
        btn_db = 4'b1011;
        step();
        btn_db = 4'b0000;
        steps(8);
        check("rr count", 32'(evq.size() - ev_base), 3);
        check_evt("rr first", 0, 2'd3, T_SHORT);
        check_evt("rr second", 1, 2'd0, T_SHORT);
        check_evt("rr third", 2, 2'd1, T_SHORT);
        check_gap("rr gap0", 0, 1);
        check_gap("rr gap1", 1, 1);

        // Backpressure: three SHORTs on button 2 with evt_ready low.
        mark();
        evt_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            btn_db[2] = 1'b1;
            step();
            btn_db[2] = 1'b0;
            step();
        end
        steps(4);
        check("bp evt_valid", 32'(evt_valid), 1);
        check("bp evt_id", 32'(evt_id), 2);
        check("bp evt_type", 32'(evt_type), 32'(T_SHORT));
        check("bp overflow", 32'(overflow), 1);
        steps(3);
        check("bp hold valid", 32'(evt_valid), 1);
        check("bp hold id", 32'(evt_id), 2);
        evt_ready = 1'b1;
        steps(6);
        check("bp delivered", 32'(evq.size() - ev_base), 2);
        check_evt("bp ev0", 0, 2'd2, T_SHORT);
        check_evt("bp ev1", 1, 2'd2, T_SHORT);
        check("bp valid drops", 32'(evt_valid), 0);
        check("bp overflow sticky", 32'(overflow), 1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        check("bp overflow cleared", 32'(overflow), 0);

        // Reset at tick 6 of a hold on button 1; the held level must not re-trigger.
        mark();
        btn_db[1] = 1'b1;
        ticks = 0;
        for (int c = 0; c < 100 && ticks < 6; c++) begin
            step();
            if (presc == TICK_DIV - 1) ticks++;
        end
        reset = 1'b1;
        #1;
        check("mid reset evt_valid", 32'(evt_valid), 0);
        check("mid reset evt_id", 32'(evt_id), 0);
        check("mid reset evt_type", 32'(evt_type), 0);
        check("mid reset overflow", 32'(overflow), 0);
        steps(2);
        reset = 1'b0;
        steps(60);
        check("post reset no event", 32'(evq.size() - ev_base), 0);
        btn_db[1] = 1'b0;
        steps(2);
        btn_db[1] = 1'b1;
        step();
        btn_db[1] = 1'b0;
        steps(8);
        check("new press count", 32'(evq.size() - ev_base), 1);
        check_evt("new press", 0, 2'd1, T_SHORT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
- Sequences NUM_BTN already-debounced button levels into discrete press events: SHORT, LONG, REPEAT and RELEASE_LONG.
- Arbitrates all buttons round-robin onto one valid/ready event port.
- Sits between the per-button debouncers and the UI/control FSM, so the consumer sees one event stream instead of raw levels.

Parameters:
- NUM_BTN, 4: number of debounced button inputs (2..8).
- TICK_DIV, 12_000: clk cycles per 1 ms timebase tick.
- LONG_MS, 1000: ticks held before a LONG event.
- REPEAT_MS, 200: ticks between REPEAT events after LONG (only with the optional feature).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- btn_db, input, NUM_BTN: debounced levels, 1 = pressed, synchronous to clk.
- evt_valid, output, 1: event available.
- evt_ready, input, 1: consumer accepts the event when evt_valid && evt_ready.
- evt_id, output, $clog2(NUM_BTN): index of the button that caused the event.
- evt_type, output, 2: 00 = SHORT, 01 = LONG, 10 = REPEAT, 11 = RELEASE_LONG.
- overflow, output, 1: sticky flag, an event was dropped.
- overflow_clr, input, 1: synchronous clear of overflow.

Behaviour:
- Reset (asynchronous, active-high; clock clk): evt_valid=0, evt_id=0, evt_type=0, overflow=0. Tick prescaler=0. All button FSMs go to IDLE, all pending flags cleared, round-robin pointer=0. Reset during a hold discards that press; no event is produced.
- Timebase: prescaler counts 0..TICK_DIV-1 and asserts a 1-cycle tick at wrap. It is free-running, so the first tick of a hold falls 1..TICK_DIV cycles after the press.
- Press edge detect: previous btn_db is registered per button; the press edge is btn_db=1 while previous=0.
- Per-button FSM and hold counter:
  - Hold counter width is $clog2(LONG_MS+1); it saturates and never wraps.
  - IDLE: on press edge, go to PRESSED and clear the hold counter.
  - PRESSED: increment the hold counter on each tick. If released, emit SHORT and go to IDLE. If the counter reaches LONG_MS, emit LONG, go to HELD and clear the counter.
  - HELD: if released, emit RELEASE_LONG and go to IDLE. Otherwise see the optional feature.
  - If release and the LONG threshold occur in the same cycle, release wins: emit SHORT.
- Pending buffer: one entry per button (valid bit + type), written the cycle after the FSM emits.
  - If the button's entry is already valid and not being granted that cycle, the new event is dropped and overflow is set.
  - If a grant and a new emit for the same button occur in the same cycle, the old entry leaves, the new one is stored, and overflow is not set.
- Arbiter:
  - When the output register is empty, or is being accepted this cycle, select the first valid pending entry searching from (last_grant+1) mod NUM_BTN.
  - Load evt_id/evt_type, set evt_valid, clear that pending entry, update last_grant.
  - Back-to-back grants are allowed, giving 1 event/cycle throughput.
- Output handshake: while evt_valid=1 && evt_ready=0, evt_id and evt_type hold stable. evt_valid drops only after acceptance with no pending entries.
- Latency: FSM emit in cycle N puts evt_valid=1 in cycle N+2 when the output register is idle.
- overflow_clr has priority below a same-cycle new overflow, so overflow stays 1.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: in HELD the counter increments on each tick; at REPEAT_MS it emits REPEAT and clears the counter, repeating until release.
- Undefined: HELD only waits for release and type 10 is never generated. REPEAT_MS is unused and no repeat logic is synthesized.

Test Plan:
- Sim parameters: TICK_DIV=4, LONG_MS=10, REPEAT_MS=3; evt_ready=1 unless stated otherwise.
- Short press: btn_db[2] high for 20 cycles (5 ticks), then low -> one event, id=2, type=00, evt_valid high for 1 cycle, no other events.
- Long hold, feature off: btn_db[1] held 80 cycles -> LONG (id=1, type=01) when the counter reaches 10. Release -> RELEASE_LONG (type=11). Exactly 2 events total.
- Auto-repeat, BTN_AUTOREPEAT_EN defined: btn_db[0] held until the 10th tick, then 9 more ticks -> LONG followed by 3 REPEATs spaced 12 cycles apart, then RELEASE_LONG on release.
- Round-robin fairness: buttons 0, 1 and 3 emit SHORT in the same cycle with last_grant=1 -> output order id 3, 0, 1 on consecutive cycles.
- Backpressure and overflow: evt_ready=0 while button 2 produces three SHORTs -> first SHORT held stable in the output register, second SHORT pending, third dropped, overflow=1. Raise evt_ready -> 2 events delivered. Pulse overflow_clr -> overflow=0.
- Reset mid-hold: assert reset at tick 6 of a hold on button 1 -> all outputs 0 immediately. Deassert with btn_db[1] still high -> no event until a new press edge.
